// File: rtl/oscillator_period_meter_pkg.sv
// Shared constants for the oscillator period meter: sample/period/peak widths,
// crossing-FSM state encodings and the clamped magnitude helper.
package oscillator_period_meter_pkg;

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned PERIOD_W = 14;
   localparam int unsigned PEAK_W   = 11;

   typedef enum logic [1:0] {
      ACQ_NEG = 2'd0,
      ACQ_POS = 2'd1,
      RUN_NEG = 2'd2,
      RUN_POS = 2'd3
   } state_e;

   // |s| limited to PEAK_W bits; the most negative sample has no positive twin
   function automatic logic [PEAK_W-1:0] abs_clamp(input logic signed [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-1:0] mag;
      mag = s[SAMPLE_W-1] ? SAMPLE_W'(-s) : SAMPLE_W'(s);
      return mag[SAMPLE_W-1] ? {PEAK_W{1'b1}} : mag[PEAK_W-1:0];
   endfunction

endpackage

// File: rtl/pulse_synchronizer.sv
// Brings an asynchronous level into the local clock domain and emits a
// one-cycle pulse for each synchronized rising edge.
module pulse_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse_c
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pulse_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/oscillator_period_meter.sv
// Measures the period (in samples) and peak magnitude of a slow oscillator
// by tracking hysteretic positive-going crossings of its sampled waveform.
module oscillator_period_meter
   import oscillator_period_meter_pkg::SAMPLE_W;
   import oscillator_period_meter_pkg::PEAK_W;
   import oscillator_period_meter_pkg::state_e;
   import oscillator_period_meter_pkg::ACQ_NEG;
   import oscillator_period_meter_pkg::ACQ_POS;
   import oscillator_period_meter_pkg::RUN_NEG;
   import oscillator_period_meter_pkg::RUN_POS;
   import oscillator_period_meter_pkg::abs_clamp;
#(
   parameter logic signed [11:0] HYST     = 12'sd64,
   parameter int unsigned        PERIOD_W = 14
) (
   input  logic                qzt_clk,
   input  logic                reset,
   input  logic                clk_in,
   input  logic [SAMPLE_W-1:0] wave,
   input  logic                restart,
   input  logic                hold,
   output logic [PERIOD_W-1:0] period,
   output logic [PEAK_W-1:0]   peak,
   output logic                valid,
   output logic                overflow
);

   localparam logic signed [SAMPLE_W-1:0] POS_HYST = HYST;
   localparam logic signed [SAMPLE_W-1:0] NEG_HYST = -HYST;
   localparam logic [PERIOD_W-1:0]        CNT_MAX  = {PERIOD_W{1'b1}};

   logic                       tick_c;
   logic                       tick_q, tick_d;
   logic signed [SAMPLE_W-1:0] sample_q, sample_d;
   state_e                     state_q, state_d;
   logic [PERIOD_W-1:0]        cnt_q, cnt_d;
   logic [PEAK_W-1:0]          pk_q, pk_d;
   logic [PERIOD_W-1:0]        period_q, period_d;
   logic [PEAK_W-1:0]          peak_q, peak_d;
   logic                       valid_q, valid_d;
   logic                       ovf_q, ovf_d;

   logic                       is_pos_c, is_neg_c;
   logic [PEAK_W-1:0]          mag_c, pk_upd_c;
   logic [PERIOD_W-1:0]        cnt_inc_c;

   pulse_synchronizer #(
      .STAGES(2)
   ) u_clk_in_sync (
      .clk      (qzt_clk),
      .rst      (reset),
      .async_in (clk_in),
      .pulse_c  (tick_c)
   );

   // Capture the sample on the tick; decisions run one cycle later on the stored copy
   always_comb begin
      sample_d = sample_q;
      if (tick_c) sample_d = wave;
      tick_d = tick_c & ~restart;
   end

   always_comb begin
      is_pos_c  = (sample_q >= POS_HYST);
      is_neg_c  = (sample_q <= NEG_HYST);
      mag_c     = abs_clamp(sample_q);
      pk_upd_c  = (mag_c > pk_q) ? mag_c : pk_q;
      cnt_inc_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_W'(1);
   end

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         state_q <= ACQ_NEG;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = ACQ_NEG;
      end else if (tick_q) begin
         case (state_q)
            ACQ_NEG: if (is_neg_c) state_d = ACQ_POS;
            ACQ_POS: if (is_pos_c) state_d = RUN_NEG;
            RUN_NEG: if (is_neg_c) state_d = RUN_POS;
            RUN_POS: if (is_pos_c) state_d = RUN_NEG;
            default: state_d = ACQ_NEG;
         endcase
      end
   end

   // Counting, peak tracking and publishing; the closing crossing belongs to the period it ends
   always_comb begin
      cnt_d    = cnt_q;
      pk_d     = pk_q;
      period_d = period_q;
      peak_d   = peak_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;
      if (restart) begin
         cnt_d = '0;
         pk_d  = '0;
         ovf_d = 1'b0;
      end else if (tick_q) begin
         case (state_q)
            ACQ_POS: begin
               if (is_pos_c) begin
                  cnt_d = '0;
                  pk_d  = '0;
               end
            end
            RUN_NEG, RUN_POS: begin
               cnt_d = cnt_inc_c;
               pk_d  = pk_upd_c;
               if (cnt_inc_c == CNT_MAX) ovf_d = 1'b1;
               if (state_q == RUN_POS && is_pos_c) begin
                  cnt_d = '0;
                  pk_d  = '0;
                  if (!hold) begin
                     period_d = cnt_inc_c;
                     peak_d   = pk_upd_c;
                     valid_d  = 1'b1;
                  end
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         tick_q   <= 1'b0;
         sample_q <= '0;
         cnt_q    <= '0;
         pk_q     <= '0;
         period_q <= '0;
         peak_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         sample_q <= sample_d;
         cnt_q    <= cnt_d;
         pk_q     <= pk_d;
         period_q <= period_d;
         peak_q   <= peak_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign period   = period_q;
   assign peak     = peak_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_oscillator_period_meter.sv
// Self-checking bench: a segment-based reference model predicts every publish,
// and a per-cycle compare process checks all outputs against it.
module tb_oscillator_period_meter;

   localparam int HYST = 64;
   localparam int PMAX = 16383;

   logic        qzt_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        clk_in  = 1'b0;
   logic [11:0] wave    = '0;
   logic        restart = 1'b0;
   logic        hold    = 1'b0;
   logic [13:0] period;
   logic [10:0] peak;
   logic        valid;
   logic        overflow;

   oscillator_period_meter #(
      .HYST     (12'sd64),
      .PERIOD_W (14)
   ) dut (
      .qzt_clk  (qzt_clk),
      .reset    (reset),
      .clk_in   (clk_in),
      .wave     (wave),
      .restart  (restart),
      .hold     (hold),
      .period   (period),
      .peak     (peak),
      .valid    (valid),
      .overflow (overflow)
   );

   always #10 qzt_clk = ~qzt_clk;

   int cyc = 0;
   always @(posedge qzt_clk) cyc++;

   typedef struct {
      int due;
      bit clr_all;
      bit clr_ovf;
      bit set_ovf;
      bit pub;
      int per;
      int pk;
   } ev_t;

   ev_t evq[$];
   int  n_cmp   = 0;
   int  n_bad   = 0;
   int  n_valid = 0;

   // reference model: samples seen since the last positive crossing
   bit  m_have_neg = 0;
   bit  m_locked   = 0;
   bit  m_seen_neg = 0;
   int  seg[$];

   int  exp_period = 0;
   int  exp_peak   = 0;
   int  exp_ovf    = 0;
   int  exp_valid  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t new_ev(input int due);
      ev_t e;
      e.due = due; e.clr_all = 0; e.clr_ovf = 0; e.set_ovf = 0;
      e.pub = 0; e.per = 0; e.pk = 0;
      return e;
   endfunction

   function automatic int abs_clamp(input int s);
      int a;
      a = (s < 0) ? -s : s;
      return (a > 2047) ? 2047 : a;
   endfunction

   task automatic model_clear();
      m_have_neg = 0;
      m_locked   = 0;
      m_seen_neg = 0;
      seg.delete();
   endtask

   task automatic model_tick(input int s, input int due);
      ev_t e;
      int  mx;
      e = new_ev(due);
      if (restart) return;
      if (!m_locked) begin
         if (!m_have_neg) begin
            if (s <= -HYST) m_have_neg = 1;
         end else if (s >= HYST) begin
            m_locked   = 1;
            m_seen_neg = 0;
            seg.delete();
         end
      end else begin
         seg.push_back(s);
         if (seg.size() >= PMAX) e.set_ovf = 1;
         if (!m_seen_neg) begin
            if (s <= -HYST) m_seen_neg = 1;
         end else if (s >= HYST) begin
            if (!hold) begin
               mx = 0;
               foreach (seg[i]) if (abs_clamp(seg[i]) > mx) mx = abs_clamp(seg[i]);
               e.pub = 1;
               e.per = (seg.size() > PMAX) ? PMAX : seg.size();
               e.pk  = mx;
            end
            seg.delete();
            m_seen_neg = 0;
         end
      end
      if (e.set_ovf || e.pub) evq.push_back(e);
   endtask

   // one clk_in period: high for 2 qzt cycles, low for lo cycles
   task automatic tick(input int s, input int lo);
      @(negedge qzt_clk);
      wave   = 12'(s);
      clk_in = 1'b1;
      model_tick(s, cyc + 4);
      repeat (2) @(negedge qzt_clk);
      clk_in = 1'b0;
      repeat (lo - 1) @(negedge qzt_clk);
   endtask

   task automatic drain();
      repeat (8) @(negedge qzt_clk);
   endtask

   task automatic set_ctrl(input bit r, input bit h);
      drain();
      if (r && !restart) begin
         evq.push_back(new_ev(cyc + 1));
         evq[evq.size()-1].clr_ovf = 1;
         model_clear();
      end
      restart = r;
      hold    = h;
   endtask

   task automatic do_reset();
      ev_t e;
      drain();
      @(posedge qzt_clk);
      #1;
      reset = 1'b1;
      evq.delete();
      e = new_ev(cyc);
      e.clr_all = 1;
      evq.push_back(e);
      model_clear();
      repeat (3) @(negedge qzt_clk);
      reset = 1'b0;
   endtask

   function automatic int rand_sample(input int sgn);
      case ($urandom_range(0, 5))
         0:       return sgn * HYST;
         1:       return sgn * (HYST - 1);
         2:       return int'($urandom_range(0, 4095)) - 2048;
         3:       return (sgn < 0) ? -2048 : 2047;
         default: return sgn * int'($urandom_range(HYST, 2047));
      endcase
   endfunction

   // per-cycle compare against the model's expectations
   initial begin
      ev_t e;
      forever begin
         @(negedge qzt_clk);
         exp_valid = 0;
         while (evq.size() > 0 && evq[0].due <= cyc) begin
            e = evq.pop_front();
            if (e.clr_all) begin exp_period = 0; exp_peak = 0; exp_ovf = 0; end
            if (e.clr_ovf) exp_ovf = 0;
            if (e.set_ovf) exp_ovf = 1;
            if (e.pub) begin exp_valid = 1; exp_period = e.per; exp_peak = e.pk; end
         end
         if (cyc >= 2) begin
            check("valid",    int'(valid),    exp_valid);
            check("period",   int'(period),   exp_period);
            check("peak",     int'(peak),     exp_peak);
            check("overflow", int'(overflow), exp_ovf);
            if (valid) n_valid++;
         end
      end
   end

   initial begin
      int nv0;
      int sgn;
      repeat (4) @(negedge qzt_clk);
      reset = 1'b0;
      check("reset_period", int'(period), 0);
      check("reset_valid",  int'(valid),  0);

      // constant positive input never locks
      for (int i = 0; i < 5; i++) tick(1000, 2);
      drain();
      check("const_period", int'(period), 0);
      check("const_peak",   int'(peak),   0);
      check("const_nvalid", n_valid,      0);

      // square wave, 10 high / 10 low
      nv0 = n_valid;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 10; i++) tick(500, 2);
         for (int i = 0; i < 10; i++) tick(-500, 2);
      end
      drain();
      check("sq_period", int'(period), 20);
      check("sq_peak",   int'(peak),   500);
      check("sq_nvalid", n_valid - nv0, 4);

      // reset mid-period discards the partial measurement
      for (int i = 0; i < 5; i++) tick(500, 2);
      do_reset();
      check("rst_period", int'(period), 0);
      nv0 = n_valid;
      tick(-500, 2);
      tick(500, 2);
      for (int i = 0; i < 3; i++) tick(-2048, 2);
      drain();
      check("rst_nvalid", n_valid - nv0, 0);
      tick(100, 2);
      drain();
      check("clamp_peak",   int'(peak),   2047);
      check("clamp_period", int'(period), 4);
      check("clamp_nvalid", n_valid - nv0, 1);

      // inside the hysteresis band nothing happens
      set_ctrl(1, 0);
      tick(-500, 2);
      set_ctrl(0, 0);
      nv0 = n_valid;
      for (int i = 0; i < 1000; i++)
         tick((i % 3 == 2) ? int'($urandom_range(0, 126)) - 63 : ((i % 2 == 0) ? 40 : -40), 2);
      drain();
      check("band_nvalid", n_valid - nv0, 0);
      tick(-500, 2); tick(500, 2); tick(-500, 2); tick(500, 2);
      drain();
      check("band_period", int'(period), 2);
      check("band_peak",   int'(peak),   500);

      // hold across a crossing
      nv0 = n_valid;
      tick(-500, 2); tick(-500, 2);
      set_ctrl(0, 1);
      tick(500, 2);
      drain();
      check("hold_nvalid", n_valid - nv0, 0);
      check("hold_period", int'(period), 2);
      set_ctrl(0, 0);
      tick(-300, 2); tick(300, 2);
      drain();
      check("after_hold_period", int'(period), 2);
      check("after_hold_peak",   int'(peak),   300);

      // saturation of the period counter
      for (int i = 0; i < 16500; i++) tick(1000, 1);
      tick(-1000, 2);
      tick(1000, 2);
      drain();
      check("ovf_flag",   int'(overflow), 1);
      check("ovf_period", int'(period),   PMAX);
      check("ovf_peak",   int'(peak),     1000);

      // restart together with a closing tick
      tick(-500, 2);
      nv0 = n_valid;
      set_ctrl(1, 0);
      tick(500, 2);
      set_ctrl(0, 0);
      drain();
      check("rs_nvalid",   n_valid - nv0,  0);
      check("rs_overflow", int'(overflow), 0);
      check("rs_period",   int'(period),   PMAX);

      // randomized segments
      sgn = 1;
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 4) == 0) set_ctrl(0, $urandom_range(0, 2) == 0);
         for (int i = 0, n = int'($urandom_range(1, 12)); i < n; i++)
            tick(rand_sample(sgn), int'($urandom_range(1, 2)));
         sgn = -sgn;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
